fpu_op_sequencer: RTL
=====================

FPU_OP_SEQUENCER -- requirements
Module: fpu_op_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the operand-pair buffer depth (power of two, 2..16).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 100, meaning the number of cycles operands are held on the fpu before its result is sampled (>=2).
REQ-003 SHALL have port clock100KHz  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have port in_valid  in  1  operand pair offered.
REQ-006 SHALL have port in_ready  out  1  sequencer can accept a pair.
REQ-007 SHALL have ports in_a and in_b  in  32 each  operands in the fpu format: sign[31], exponent[30:25] with bias 31, mantissa[24:0].
REQ-008 SHALL have ports op_A_out and op_B_out  out  32 each  registered operands driven to fpu op_A_in/op_B_in.
REQ-009 SHALL have port fpu_data_in  in  32  fpu data_out.
REQ-010 SHALL have port fpu_status_in  in  4  fpu status_out.
REQ-011 SHALL have ports res_valid  out  1 and res_ready  in  1  result handshake.
REQ-012 SHALL have ports res_data  out  32 and res_status  out  4  captured fpu result and status.
REQ-013 SHALL have port fill  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-014 SHALL accept a pair on a rising edge where in_valid=1 and in_ready=1; in_ready = (fill < FIFO_DEPTH) and reset deasserted.
REQ-015 SHALL store accepted pairs first-in first-out; a simultaneous push and pop SHALL leave fill unchanged, and a push into a full FIFO SHALL never occur.
REQ-016 SHALL implement the FSM states IDLE, DRIVE and PRESENT.
REQ-017 IDLE with fill>0: SHALL pop the head pair into op_A_out/op_B_out, load the settle counter with SETTLE_CYCLES-1, and go to DRIVE; IDLE with fill=0: SHALL stay in IDLE with op outputs unchanged.
REQ-018 DRIVE: SHALL decrement the counter each cycle; at counter=0 it SHALL register fpu_data_in into res_data and fpu_status_in into res_status, set res_valid=1, and go to PRESENT.
REQ-019 Latency: a pair accepted into an empty FIFO in IDLE at edge t SHALL appear on op outputs after edge t+1, with res_valid rising after edge t+1+SETTLE_CYCLES.
REQ-020 PRESENT: res_valid, res_data, res_status, op_A_out and op_B_out SHALL remain stable until res_ready=1; at that edge res_valid SHALL clear and the FSM SHALL go to IDLE (one bubble cycle).
REQ-021 Pushes SHALL continue to be accepted in DRIVE and PRESENT while the FIFO is not full.
REQ-022 The sequencer SHALL never inspect or modify operand or result bit fields (pure transport).
REQ-023 The fpu's own reset SHALL NOT be driven by this block.

Reset
REQ-024 While reset=0, at each edge: FSM state SHALL become IDLE, FIFO pointers and fill SHALL become 0, counter SHALL become 0, op_A_out/op_B_out/res_data SHALL become 32'h0, res_status SHALL become 4'h0, and res_valid SHALL become 0.
REQ-025 in_ready SHALL be 0 while reset=0 and SHALL be 1 in the first cycle after release.
REQ-026 Reset asserted in DRIVE or PRESENT SHALL discard the in-flight pair and all buffered pairs; no result for them SHALL ever be presented.

Structure
REQ-027 Package fpu_pkg SHALL hold the format constants (sign, exponent 6 bits, mantissa 25 bits, bias 31), the status bit indices, and the sequencer state enum; the fpu shares this package.
REQ-028 The FIFO SHALL be a separate sub-module, op_fifo, holding 64-bit entries {a,b} with push, pop, full, empty and fill.

Verification (stub fpu: data = op_A_out+op_B_out mod 2^32, status = op_A_out[3:0]; SETTLE_CYCLES=100)
REQ-029 Reset: hold reset=0 for 3 cycles with in_valid=1 -> all outputs 0, in_ready=0, nothing accepted; in_ready=1 the cycle after release.
REQ-030 Single pair A=32'h3E000000, B=32'h3E000000 at edge t -> op outputs = 32'h3E000000 after t+1; res_valid after t+101 with res_data=32'h7C000000 and res_status=4'h0.
REQ-031 Six back-to-back pairs (A=1..6, B=32'h10) with res_ready=0 -> in_ready drops once fill=4, no push is lost; with res_ready=1, results arrive in order 32'h11..32'h16 with res_status 1..6.
REQ-032 Back-pressure: res_ready=0 for 50 cycles in PRESENT -> res_valid, res_data, res_status and op outputs are constant; one result consumed on the res_ready=1 edge.
REQ-033 Reset pulse at counter=40 in DRIVE with 2 pairs buffered -> FSM returns to IDLE with fill=0 and no res_valid occurs within the next 300 cycles.
REQ-034 Simultaneous push and pop with fill=2 -> fill stays at 2 and the pushed pair is the last one out.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared fpu definitions: operand format, status bit positions and the
// operand sequencer state encoding.
package fpu_pkg;

  localparam int FP_SIGN_BIT = 31;
  localparam int FP_EXP_W    = 6;
  localparam int FP_MAN_W    = 25;
  localparam int FP_BIAS     = 31;
  localparam int FP_W        = 1 + FP_EXP_W + FP_MAN_W;

  localparam int ST_INVALID   = 0;
  localparam int ST_DIVZERO   = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_UNDERFLOW = 3;
  localparam int ST_W         = 4;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_DRIVE,
    SEQ_PRESENT
  } seq_state_e;

endpackage

// File: rtl/op_fifo.sv
// Operand-pair FIFO: 64-bit {a,b} entries, power-of-two depth, head
// visible combinationally on dout.
module op_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [63:0]              din,
  input  logic                     pop,
  output logic [63:0]              dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [FW-1:0] fill_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
    end
  end

  assign dout  = mem[rd_q];
  assign full  = (fill_q == FW'(DEPTH));
  assign empty = (fill_q == '0);
  assign fill  = fill_q;

endmodule

// File: rtl/fpu_op_sequencer.sv
// Feeds buffered operand pairs to a combinational fpu one at a time, holds
// them for SETTLE_CYCLES, then presents the sampled result with a handshake.
module fpu_op_sequencer
  import fpu_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 100
) (
  input  logic                        clock100KHz,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [FP_W-1:0]             in_a,
  input  logic [FP_W-1:0]             in_b,
  output logic [FP_W-1:0]             op_A_out,
  output logic [FP_W-1:0]             op_B_out,
  input  logic [FP_W-1:0]             fpu_data_in,
  input  logic [ST_W-1:0]             fpu_status_in,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [FP_W-1:0]             res_data,
  output logic [ST_W-1:0]             res_status,
  output logic [$clog2(FIFO_DEPTH):0] fill
);

  localparam int CW = $clog2(SETTLE_CYCLES);

  seq_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [FP_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [FP_W-1:0] res_data_q, res_data_d;
  logic [ST_W-1:0] res_st_q, res_st_d;
  logic            res_vld_q, res_vld_d;

  logic            push, pop, full, empty;
  logic [63:0]     head;

  assign in_ready = reset & ~full;
  assign push     = in_valid & in_ready;

  op_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clock100KHz),
    .rst_n (reset),
    .push  (push),
    .din   ({in_a, in_b}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .fill  (fill)
  );

  always_ff @(posedge clock100KHz) begin
    if (!reset) begin
      state_q    <= SEQ_IDLE;
      cnt_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      res_data_q <= '0;
      res_st_q   <= '0;
      res_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      res_data_q <= res_data_d;
      res_st_q   <= res_st_d;
      res_vld_q  <= res_vld_d;
    end
  end

  // Operands stay on the fpu from the pop edge until the result is taken,
  // so the presented result always matches the visible operands.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    res_data_d = res_data_q;
    res_st_d   = res_st_q;
    res_vld_d  = res_vld_q;
    pop        = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          op_a_d  = head[63:32];
          op_b_d  = head[31:0];
          cnt_d   = CW'(SETTLE_CYCLES - 1);
          state_d = SEQ_DRIVE;
        end
      end
      SEQ_DRIVE: begin
        if (cnt_q == '0) begin
          res_data_d = fpu_data_in;
          res_st_d   = fpu_status_in;
          res_vld_d  = 1'b1;
          state_d    = SEQ_PRESENT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SEQ_PRESENT: begin
        if (res_ready) begin
          res_vld_d = 1'b0;
          state_d   = SEQ_IDLE;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  assign op_A_out   = op_a_q;
  assign op_B_out   = op_b_q;
  assign res_valid  = res_vld_q;
  assign res_data   = res_data_q;
  assign res_status = res_st_q;

endmodule
